// File: rtl/rv_pkg.sv
// Shared widths and types for the RV64 integer register file and its scoreboard.
package rv_pkg;
  localparam int XLEN      = 64;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_scoreboard_sb.sv
// Pending-write scoreboard: one busy bit per register plus the decode RAW-hazard compare.
module reg_file_scoreboard_sb
  import rv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_set,
  input  reg_idx_t         i_set_idx,
  input  logic             i_clr,
  input  reg_idx_t         i_clr_idx,
  input  reg_idx_t         i_rs1_index,
  input  reg_idx_t         i_rs2_index,
  output logic             o_hazard,
  output logic [NREGS-1:0] o_busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Clear first so a same-index set from the younger issuing instruction wins.
  always_comb begin
    busy_d = busy_q;
    if (i_clr && (i_clr_idx != REG_ZERO)) busy_d[i_clr_idx] = 1'b0;
    if (i_set && (i_set_idx != REG_ZERO)) busy_d[i_set_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Uses the current busy vector: a retiring write still stalls this cycle.
  assign o_hazard = (busy_q[i_rs1_index] && (i_rs1_index != REG_ZERO)) ||
                    (busy_q[i_rs2_index] && (i_rs2_index != REG_ZERO));
  assign o_busy   = busy_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// RV64 integer register file: two registered read ports with write-first bypass and a busy scoreboard.
module reg_file_scoreboard
  import rv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rd_we,
  input  logic [4:0]       i_rd_index,
  input  logic [XLEN-1:0]  i_rd_data,
  input  logic             i_stall,
  input  logic [4:0]       i_rs1_index,
  input  logic [4:0]       i_rs2_index,
  input  logic             i_issue,
  input  logic [4:0]       i_issue_rd,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  output logic             o_hazard,
  output logic [NREGS-1:0] o_busy
);

  xlen_t regs_q [NREGS];
  xlen_t regs_d [NREGS];
  xlen_t rs1_q, rs1_d, rs2_q, rs2_d;
  logic  wr_en;

  assign wr_en = i_rd_we && (i_rd_index != REG_ZERO);

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (wr_en) regs_d[i_rd_index] = i_rd_data;
  end

  // Operand capture: x0 forced to zero, then write-back bypass, then array.
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (!i_stall) begin
      if (i_rs1_index == REG_ZERO)                 rs1_d = '0;
      else if (wr_en && i_rd_index == i_rs1_index) rs1_d = i_rd_data;
      else                                         rs1_d = regs_q[i_rs1_index];
      if (i_rs2_index == REG_ZERO)                 rs2_d = '0;
      else if (wr_en && i_rd_index == i_rs2_index) rs2_d = i_rd_data;
      else                                         rs2_d = regs_q[i_rs2_index];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  assign o_rs1_data = rs1_q;
  assign o_rs2_data = rs2_q;

  reg_file_scoreboard_sb u_sb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_set       (i_issue),
    .i_set_idx   (i_issue_rd),
    .i_clr       (i_rd_we),
    .i_clr_idx   (i_rd_index),
    .i_rs1_index (i_rs1_index),
    .i_rs2_index (i_rs2_index),
    .o_hazard    (o_hazard),
    .o_busy      (o_busy)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard with hand-computed expected values.
module tb_reg_file_scoreboard;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rd_we;
  logic [4:0]  i_rd_index;
  logic [63:0] i_rd_data;
  logic        i_stall;
  logic [4:0]  i_rs1_index;
  logic [4:0]  i_rs2_index;
  logic        i_issue;
  logic [4:0]  i_issue_rd;
  logic [63:0] o_rs1_data;
  logic [63:0] o_rs2_data;
  logic        o_hazard;
  logic [31:0] o_busy;

  int checks = 0;
  int errors = 0;

  reg_file_scoreboard dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_we     (i_rd_we),
    .i_rd_index  (i_rd_index),
    .i_rd_data   (i_rd_data),
    .i_stall     (i_stall),
    .i_rs1_index (i_rs1_index),
    .i_rs2_index (i_rs2_index),
    .i_issue     (i_issue),
    .i_issue_rd  (i_issue_rd),
    .o_rs1_data  (o_rs1_data),
    .o_rs2_data  (o_rs2_data),
    .o_hazard    (o_hazard),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] idx, input logic [63:0] data);
    i_rd_we = we; i_rd_index = idx; i_rd_data = data;
  endtask

  initial begin
    i_rst = 1'b1; i_stall = 1'b0; i_issue = 1'b0; i_issue_rd = '0;
    i_rs1_index = '0; i_rs2_index = '0;
    wb(1'b0, 5'd0, 64'd0);
    tick(); tick();
    check("reset_rs1", o_rs1_data, 64'd0);
    check("reset_rs2", o_rs2_data, 64'd0);
    check("reset_busy", {32'd0, o_busy}, 64'd0);
    check("reset_hazard", {63'd0, o_hazard}, 64'd0);
    i_rst = 1'b0;
    tick();

    // write then read
    wb(1'b1, 5'd7, 64'h0123_4567_89AB_CDEF);
    tick();
    wb(1'b0, 5'd0, 64'd0); i_rs1_index = 5'd7;
    tick();
    check("wr_rd_x7", o_rs1_data, 64'h0123_4567_89AB_CDEF);

    // same-edge bypass on rs2
    wb(1'b1, 5'd3, 64'h55); i_rs2_index = 5'd3;
    tick();
    check("bypass_rs2", o_rs2_data, 64'h55);
    wb(1'b0, 5'd0, 64'd0);
    tick();
    check("stored_x3", o_rs2_data, 64'h55);

    // x0 stays zero and never goes busy
    wb(1'b1, 5'd0, 64'hFFFF); i_rs1_index = 5'd0; i_rs2_index = 5'd0;
    i_issue = 1'b1; i_issue_rd = 5'd0;
    tick();
    check("x0_rs1", o_rs1_data, 64'd0);
    check("x0_rs2", o_rs2_data, 64'd0);
    check("x0_busy", {32'd0, o_busy}, 64'd0);
    wb(1'b0, 5'd0, 64'd0); i_issue = 1'b0;
    tick();
    check("x0_rs1_after", o_rs1_data, 64'd0);

    // scoreboard set, hazard, clear via write-back
    i_issue = 1'b1; i_issue_rd = 5'd9;
    tick();
    i_issue = 1'b0;
    check("busy9_set", {32'd0, o_busy}, 64'h200);
    i_rs1_index = 5'd9;
    #1;
    check("hazard_rs1", {63'd0, o_hazard}, 64'd1);
    wb(1'b1, 5'd9, 64'h42);
    #1;
    check("hazard_during_wb", {63'd0, o_hazard}, 64'd1);
    tick();
    wb(1'b0, 5'd0, 64'd0);
    check("hazard_after_wb", {63'd0, o_hazard}, 64'd0);
    check("busy_after_wb", {32'd0, o_busy}, 64'd0);
    check("wb_bypass_x9", o_rs1_data, 64'h42);

    // same-index set and clear: set wins
    i_issue = 1'b1; i_issue_rd = 5'd9;
    tick();
    wb(1'b1, 5'd9, 64'h77);
    tick();
    check("set_wins", {32'd0, o_busy}, 64'h200);
    // different indices on one edge
    i_issue_rd = 5'd10;
    tick();
    check("set_clr_diff", {32'd0, o_busy}, 64'h400);
    i_issue = 1'b0;
    wb(1'b1, 5'd10, 64'h10);
    tick();
    check("clr_x10", {32'd0, o_busy}, 64'd0);
    wb(1'b1, 5'd11, 64'h11);
    tick();
    check("clr_not_busy", {32'd0, o_busy}, 64'd0);
    wb(1'b0, 5'd0, 64'd0);

    // rs2 hazard path
    i_issue = 1'b1; i_issue_rd = 5'd12;
    tick();
    i_issue = 1'b0; i_rs1_index = 5'd0; i_rs2_index = 5'd12;
    #1;
    check("hazard_rs2", {63'd0, o_hazard}, 64'd1);
    i_rs2_index = 5'd13;
    #1;
    check("no_hazard_rs2", {63'd0, o_hazard}, 64'd0);
    wb(1'b1, 5'd12, 64'h12);
    tick();
    wb(1'b0, 5'd0, 64'd0);

    // stall holds outputs
    wb(1'b1, 5'd4, 64'h4444);
    tick();
    wb(1'b1, 5'd6, 64'h6666);
    tick();
    wb(1'b0, 5'd0, 64'd0); i_rs1_index = 5'd4;
    tick();
    check("pre_stall_x4", o_rs1_data, 64'h4444);
    i_stall = 1'b1; i_rs1_index = 5'd6;
    tick();
    check("stall_hold1", o_rs1_data, 64'h4444);
    tick();
    check("stall_hold2", o_rs1_data, 64'h4444);
    i_stall = 1'b0;
    tick();
    check("unstall_x6", o_rs1_data, 64'h6666);

    // mid-run async reset
    wb(1'b1, 5'd5, 64'hDEAD);
    tick();
    wb(1'b0, 5'd0, 64'd0); i_issue = 1'b1; i_issue_rd = 5'd5; i_rs1_index = 5'd5;
    tick();
    i_issue = 1'b0;
    check("pre_rst_x5", o_rs1_data, 64'hDEAD);
    check("pre_rst_busy", {32'd0, o_busy}, 64'h20);
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_rs1", o_rs1_data, 64'd0);
    check("async_rst_busy", {32'd0, o_busy}, 64'd0);
    wb(1'b1, 5'd5, 64'hBEEF);
    tick();
    check("rst_hold_rs1", o_rs1_data, 64'd0);
    i_rst = 1'b0; wb(1'b0, 5'd0, 64'd0);
    tick();
    check("post_rst_x5", o_rs1_data, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
